// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : contador_pkg
// Brief    : Shared constants and helpers for the modulo-N counter family.
// Revision : 1.0 - initial release
// ============================================================================
package contador_pkg;

  // Behaviour when the count reaches its limit
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold 0..n-1, never less than one so a register always exists
  function automatic int presc_width(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_mod_n_if.sv
`default_nettype none
// ============================================================================
// Module   : contador_mod_n_if
// Brief    : Control and status bundle of the modulo-N counter.
// Revision : 1.0 - initial release
// ============================================================================
interface contador_mod_n_if #(
  parameter int WIDTH = 3
);

  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] salida;
  logic             TC;
  logic             SAT;

  // Controller side: drives the strobes, observes the count
  modport master (
    output EN, UP, LOAD, LOAD_VAL,
    input  salida, TC, SAT
  );

  // Counter side
  modport slave (
    input  EN, UP, LOAD, LOAD_VAL,
    output salida, TC, SAT
  );

endinterface
`default_nettype wire

// File: rtl/contador_mod_n_presc_tick.sv
`default_nettype none
// ============================================================================
// Module   : presc_tick
// Brief    : Clock-enable prescaler; TICK fires on every PRESC-th enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module presc_tick
  import contador_pkg::*;
#(
  parameter int PRESC = 1
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic EN,
  input  wire logic CLR,
  output logic      TICK
);

  generate
    if (PRESC == 1) begin : g_no_presc
      // Every enabled cycle is a step; no phase to remember
      logic w_unused;
      assign w_unused = ^{CLK, RST, CLR};
      assign TICK     = EN;
    end else begin : g_presc
      localparam int              c_PW   = presc_width(PRESC);
      localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESC - 1);

      logic [c_PW-1:0] r_p;

      // Phase counter: cleared by reset or CLR, frozen while EN is low
      always_ff @(posedge CLK) begin
        if (!RST) begin
          r_p <= '0;
        end else if (CLR) begin
          r_p <= '0;
        end else if (EN) begin
          r_p <= (r_p == c_LAST) ? '0 : r_p + c_PW'(1);
        end
      end

      assign TICK = EN & (r_p == c_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/contador_mod_n.sv
`default_nettype none
// ============================================================================
// Module   : contador_mod_n
// Brief    : Up/down modulo-N counter with prescaler, load, wrap or saturate.
// Revision : 1.0 - initial release
// ============================================================================
module contador_mod_n
  import contador_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int MODULO = 8,
  parameter int PRESC  = 1,
  parameter int MODE   = MODE_WRAP
) (
  input wire logic          CLK,
  input wire logic          RST,
  contador_mod_n_if.slave   bus
);

  // Largest reachable count; MODULO may equal 2**WIDTH, so MODULO-1 always fits
  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;
  logic             r_sat;
  logic             w_step;
  logic [WIDTH-1:0] w_load_val;

  presc_tick #(
    .PRESC (PRESC)
  ) u_presc (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (bus.EN),
    .CLR  (bus.LOAD),
    .TICK (w_step)
  );

  // Out-of-range load values are clamped to the top of the range
  assign w_load_val = (bus.LOAD_VAL > c_MAX) ? c_MAX : bus.LOAD_VAL;

  // Count state: reset > load > step > hold; TC only survives one edge
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
      r_sat <= 1'b0;
    end else if (bus.LOAD) begin
      r_cnt <= w_load_val;
      r_tc  <= 1'b0;
      r_sat <= 1'b0;
    end else if (w_step) begin
      r_tc <= 1'b0;
      if (bus.UP) begin
        if (r_cnt < c_MAX) begin
          r_cnt <= r_cnt + WIDTH'(1);
          r_sat <= 1'b0;
        end else if (MODE == MODE_SAT) begin
          r_sat <= 1'b1;
        end else begin
          r_cnt <= '0;
          r_tc  <= 1'b1;
        end
      end else begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - WIDTH'(1);
          r_sat <= 1'b0;
        end else if (MODE == MODE_SAT) begin
          r_sat <= 1'b1;
        end else begin
          r_cnt <= c_MAX;
          r_tc  <= 1'b1;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign bus.salida = r_cnt;
  assign bus.TC     = r_tc;
  assign bus.SAT    = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_contador_mod_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_mod_n
// Brief    : Directed self-checking bench for contador_mod_n in four configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_mod_n;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // d0: wrap mod 5; d1: saturate mod 5; d2: prescaled mod 4; d3: full range mod 8
  contador_mod_n_if #(.WIDTH(3)) bus0 ();
  contador_mod_n_if #(.WIDTH(3)) bus1 ();
  contador_mod_n_if #(.WIDTH(3)) bus2 ();
  contador_mod_n_if #(.WIDTH(3)) bus3 ();

  contador_mod_n #(.WIDTH(3), .MODULO(5), .PRESC(1), .MODE(0)) d0 (.CLK(clk), .RST(rst), .bus(bus0));
  contador_mod_n #(.WIDTH(3), .MODULO(5), .PRESC(1), .MODE(1)) d1 (.CLK(clk), .RST(rst), .bus(bus1));
  contador_mod_n #(.WIDTH(3), .MODULO(4), .PRESC(3), .MODE(0)) d2 (.CLK(clk), .RST(rst), .bus(bus2));
  contador_mod_n #(.WIDTH(3), .MODULO(8), .PRESC(1), .MODE(0)) d3 (.CLK(clk), .RST(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    if (bus0.salida !== 3'd0 || bus0.TC !== 1'b0 || bus0.SAT !== 1'b0) begin
      $display("FAIL reset_d0: got salida=%0d TC=%b SAT=%b, want 0/0/0", bus0.salida, bus0.TC, bus0.SAT);
      n_err++;
    end
    n_cmp++;
    if (bus1.salida !== 3'd0 || bus1.TC !== 1'b0 || bus1.SAT !== 1'b0) begin
      $display("FAIL reset_d1: got salida=%0d TC=%b SAT=%b, want 0/0/0", bus1.salida, bus1.TC, bus1.SAT);
      n_err++;
    end
    n_cmp++;
    if (bus2.salida !== 3'd0 || bus2.TC !== 1'b0 || bus2.SAT !== 1'b0) begin
      $display("FAIL reset_d2: got salida=%0d TC=%b SAT=%b, want 0/0/0", bus2.salida, bus2.TC, bus2.SAT);
      n_err++;
    end
    n_cmp++;
    if (bus3.salida !== 3'd0 || bus3.TC !== 1'b0 || bus3.SAT !== 1'b0) begin
      $display("FAIL reset_d3: got salida=%0d TC=%b SAT=%b, want 0/0/0", bus3.salida, bus3.TC, bus3.SAT);
      n_err++;
    end
    n_cmp++;
    rst = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [2:0] exp_s [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    logic       exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus0.UP = 1'b1;
    bus0.EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus0.salida !== exp_s[i] || bus0.TC !== exp_t[i]) begin
        $display("FAIL wrap_up[%0d]: got salida=%0d TC=%b, want %0d/%b", i, bus0.salida, bus0.TC, exp_s[i], exp_t[i]);
        n_err++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_load_clamp();
    // Load 7 into a mod-5 counter while a step is also due
    bus0.LOAD     = 1'b1;
    bus0.LOAD_VAL = 3'd7;
    tick();
    if (bus0.salida !== 3'd4 || bus0.TC !== 1'b0) begin
      $display("FAIL load_clamp: got salida=%0d TC=%b, want 4/0", bus0.salida, bus0.TC);
      n_err++;
    end
    n_cmp++;
    bus0.LOAD = 1'b0;
    tick();
    if (bus0.salida !== 3'd0 || bus0.TC !== 1'b1) begin
      $display("FAIL load_then_wrap: got salida=%0d TC=%b, want 0/1", bus0.salida, bus0.TC);
      n_err++;
    end
    n_cmp++;
    // Load with the counter disabled
    bus0.EN       = 1'b0;
    bus0.LOAD     = 1'b1;
    bus0.LOAD_VAL = 3'd3;
    tick();
    if (bus0.salida !== 3'd3 || bus0.TC !== 1'b0) begin
      $display("FAIL load_en0: got salida=%0d TC=%b, want 3/0", bus0.salida, bus0.TC);
      n_err++;
    end
    n_cmp++;
    bus0.LOAD = 1'b0;
    tick();
    if (bus0.salida !== 3'd3 || bus0.TC !== 1'b0) begin
      $display("FAIL hold_en0: got salida=%0d TC=%b, want 3/0", bus0.salida, bus0.TC);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_down_sat();
    logic [2:0] exp_s [4] = '{3'd1, 3'd0, 3'd0, 3'd0};
    logic       exp_q [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bus1.LOAD     = 1'b1;
    bus1.LOAD_VAL = 3'd2;
    tick();
    if (bus1.salida !== 3'd2 || bus1.SAT !== 1'b0) begin
      $display("FAIL sat_load: got salida=%0d SAT=%b, want 2/0", bus1.salida, bus1.SAT);
      n_err++;
    end
    n_cmp++;
    bus1.LOAD = 1'b0;
    bus1.UP   = 1'b0;
    bus1.EN   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus1.salida !== exp_s[i] || bus1.SAT !== exp_q[i] || bus1.TC !== 1'b0) begin
        $display("FAIL down_sat[%0d]: got salida=%0d SAT=%b TC=%b, want %0d/%b/0", i, bus1.salida, bus1.SAT, bus1.TC, exp_s[i], exp_q[i]);
        n_err++;
      end
      n_cmp++;
    end
    bus1.UP = 1'b1;
    tick();
    if (bus1.salida !== 3'd1 || bus1.SAT !== 1'b0 || bus1.TC !== 1'b0) begin
      $display("FAIL sat_release: got salida=%0d SAT=%b TC=%b, want 1/0/0", bus1.salida, bus1.SAT, bus1.TC);
      n_err++;
    end
    n_cmp++;
    bus1.EN = 1'b0;
  endtask

  task automatic test_prescaler();
    logic       en_v  [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] exp_s [15] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
                               3'd2, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0};
    logic       exp_t [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus2.UP = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus2.EN = en_v[i];
      tick();
      if (bus2.salida !== exp_s[i] || bus2.TC !== exp_t[i]) begin
        $display("FAIL presc[%0d]: got salida=%0d TC=%b, want %0d/%b", i, bus2.salida, bus2.TC, exp_s[i], exp_t[i]);
        n_err++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_s [3] = '{3'd0, 3'd0, 3'd1};
    // Phase is 1 of 3 at entry; nine edges reach count 3 with phase 1
    bus2.EN = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    if (bus2.salida !== 3'd3) begin
      $display("FAIL pre_reset: got salida=%0d, want 3", bus2.salida);
      n_err++;
    end
    n_cmp++;
    rst = 1'b0;
    tick();
    if (bus2.salida !== 3'd0 || bus2.TC !== 1'b0 || bus2.SAT !== 1'b0) begin
      $display("FAIL reset_mid: got salida=%0d TC=%b SAT=%b, want 0/0/0", bus2.salida, bus2.TC, bus2.SAT);
      n_err++;
    end
    n_cmp++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus2.salida !== exp_s[i]) begin
        $display("FAIL post_reset[%0d]: got salida=%0d, want %0d", i, bus2.salida, exp_s[i]);
        n_err++;
      end
      n_cmp++;
    end
    bus2.EN = 1'b0;
  endtask

  task automatic test_full_range();
    logic [2:0] exp_s [4] = '{3'd7, 3'd6, 3'd7, 3'd0};
    logic       exp_t [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       up_v  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bus3.EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus3.UP = up_v[i];
      tick();
      if (bus3.salida !== exp_s[i] || bus3.TC !== exp_t[i]) begin
        $display("FAIL full_range[%0d]: got salida=%0d TC=%b, want %0d/%b", i, bus3.salida, bus3.TC, exp_s[i], exp_t[i]);
        n_err++;
      end
      n_cmp++;
    end
    bus3.EN = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus0.EN = 1'b0; bus0.UP = 1'b1; bus0.LOAD = 1'b0; bus0.LOAD_VAL = 3'd0;
    bus1.EN = 1'b0; bus1.UP = 1'b1; bus1.LOAD = 1'b0; bus1.LOAD_VAL = 3'd0;
    bus2.EN = 1'b0; bus2.UP = 1'b1; bus2.LOAD = 1'b0; bus2.LOAD_VAL = 3'd0;
    bus3.EN = 1'b0; bus3.UP = 1'b1; bus3.LOAD = 1'b0; bus3.LOAD_VAL = 3'd0;
    tick();
    test_reset();
    test_wrap_up();
    test_load_clamp();
    test_down_sat();
    test_prescaler();
    test_reset_mid();
    test_full_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/contador_mod_n.md
Name: contador_mod_n

Overview:
- Parametrised successor of the 3-bit free-running counter. Adds configurable width and modulus, a clock-enable prescaler, up/down direction, synchronous load, and wrap or saturate mode.
- Emits a one-cycle wrap pulse and a saturation flag.
- Serves as the timing-unit and symbol-position counter in the Morse transmitter. Example: dot/dash/gap durations via PRESC and MODULO, character index via LOAD.

Parameters:
- WIDTH, 3, counter/output width in bits; must be >= 1.
- MODULO, 8, count range 0..MODULO-1; 2 <= MODULO <= 2**WIDTH.
- PRESC, 1, enabled cycles per count step; PRESC >= 1 (1 = step every enabled cycle).
- MODE, 0, 0 = wrap, 1 = saturate.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-low.
- EN  in  1  count enable; low freezes counter and prescaler.
- UP  in  1  direction: 1 = up, 0 = down; sampled on each step.
- LOAD  in  1  synchronous load strobe.
- LOAD_VAL  in  WIDTH  value for LOAD.
- salida  out  WIDTH  registered count value.
- TC  out  1  registered wrap pulse, one cycle.
- SAT  out  1  registered level: counter held at limit (MODE=1 only).

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-low. While RST=0 at a rising edge, all state clears: salida=0, TC=0, SAT=0, prescaler count=0.
- Priority per edge: RST > LOAD > step > hold.
- Reset mid-count: takes effect at the next edge and discards any pending prescaler progress.
- LOAD=1 (RST=1):
  - salida <= LOAD_VAL if LOAD_VAL < MODULO, else MODULO-1 (clamp).
  - Prescaler clears to 0; TC <= 0; SAT <= 0.
  - LOAD is honoured regardless of EN.
- Prescaler: internal count p in 0..PRESC-1, advances only when EN=1 and LOAD=0.
  - step = EN & (p == PRESC-1); p wraps to 0 on step.
  - With PRESC=1 there is no prescaler register; step = EN.
- Step, up direction (UP=1):
  - If salida < MODULO-1: increment.
  - At MODULO-1 with MODE=0: salida <= 0, TC <= 1.
  - At MODULO-1 with MODE=1: hold, SAT <= 1.
- Step, down direction (UP=0):
  - If salida > 0: decrement.
  - At 0 with MODE=0: salida <= MODULO-1, TC <= 1.
  - At 0 with MODE=1: hold, SAT <= 1.
- TC: high exactly one cycle, coinciding with the first cycle salida shows the wrapped value. It is 0 on every other edge, including hold edges and edges with EN=0.
- SAT: set on a blocked step. Cleared by reset, LOAD, or any step that moves the counter. SAT is constant 0 when MODE=0.
- Direction change mid-count: takes effect at the next step. No prescaler restart.
- Non-power-of-2 MODULO: values >= MODULO are unreachable except via reset/load clamp. Arithmetic is WIDTH bits, with no intermediate overflow.
- Latency: one cycle from qualifying edge to salida/TC/SAT update. No combinational input-to-output path.

Decomposition:
- Package contador_pkg holds:
  - MODE_WRAP=0, MODE_SAT=1 constants.
  - a clog2 helper function for prescaler width (max(1, clog2(PRESC))).
- Sub-module presc_tick(CLK, RST, EN, CLR, TICK):
  - Parameter PRESC.
  - Generates the step strobe; CLR is driven by LOAD.
  - Reused by other timing blocks.
- contador_mod_n instantiates one presc_tick. Counter next-state logic stays in the top.

Test Plan:
- Wrap up: WIDTH=3, MODULO=5, PRESC=1, MODE=0, UP=1, EN=1 after RST 0->1. salida sequence 0,1,2,3,4,0,1; TC=1 only in the cycle salida returns to 0.
- Down and saturate: MODULO=5, MODE=1, UP=0, LOAD_VAL=2 loaded. salida 2,1,0,0,0; SAT goes 1 on the first blocked step and stays; TC never 1. A step with UP=1 then gives salida=1 and SAT=0.
- Prescaler: PRESC=3, MODULO=4, EN=1. salida steps every 3rd edge: 0,0,0,1,1,1,2. With EN=0 for 2 cycles mid-count, salida and prescaler phase freeze, then resume without skipping.
- Load priority and clamp:
  - LOAD=1 with LOAD_VAL=7, MODULO=5, same edge as a would-be step: salida=4, TC=0.
  - LOAD with EN=0: load still occurs.
- Reset mid-operation: RST=0 for one edge at salida=3 and prescaler mid-period. Next cycle salida=0, TC=0, SAT=0; counting resumes with a full PRESC period.
- Full-range wrap: WIDTH=3, MODULO=8, UP=0 from 0. salida 0->7 with TC=1, then 6. No X/overflow artefacts.
